// File: rtl/misr_signature_analyzer.sv
// MISR response compactor: folds NPAT accepted din words into a signature, then compares it to golden.
// Latency 1 from last accepted sample to done/pass; din_valid low stalls the run indefinitely.
module misr_signature_analyzer #(
  parameter int              WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b0011,
  parameter logic [WIDTH-1:0] SEED  = '0,
  parameter int              NPAT  = 15,
  localparam int             CW    = $clog2(NPAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CW-1:0]    count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] golden_q;
  logic [WIDTH-1:0] next_sig;
  logic             last_sample;

  // Galois step: shift left, fold the dropped MSB back through TAPS, then XOR in the new word.
  always_comb begin
    next_sig    = {signature[WIDTH-2:0], 1'b0} ^ (signature[WIDTH-1] ? TAPS : '0) ^ din;
    last_sample = (count == CW'(NPAT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      signature <= SEED;
      count     <= '0;
      golden_q  <= '0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= COMPACT;
            signature <= SEED;
            count     <= '0;
            golden_q  <= golden;
            pass      <= 1'b0;
          end
        end
        COMPACT: begin
          if (din_valid) begin
            signature <= next_sig;
            count     <= count + 1'b1;
            if (last_sample) begin
              state <= DONE;
              pass  <= (next_sig == golden_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == COMPACT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_misr_signature_analyzer.sv
// Directed bench: NPAT=3 instance driven from a vector table, default instance fed by an LFSR stream.
module tb_misr_signature_analyzer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // NPAT = 3 instance
  logic       start3 = 1'b0, vld3 = 1'b0;
  logic [3:0] din3 = '0, golden3 = '0;
  logic       busy3, done3, pass3;
  logic [3:0] sig3;
  logic [1:0] cnt3;

  // default-parameter instance
  logic       start15 = 1'b0, vld15 = 1'b0;
  logic [3:0] din15 = '0, golden15 = '0;
  logic       busy15, done15, pass15;
  logic [3:0] sig15;
  logic [3:0] cnt15;

  misr_signature_analyzer #(.WIDTH(4), .TAPS(4'b0011), .SEED(4'h0), .NPAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .din(din3), .din_valid(vld3), .golden(golden3),
    .busy(busy3), .done(done3), .pass(pass3), .signature(sig3), .count(cnt3)
  );

  misr_signature_analyzer dut15 (
    .clk(clk), .rst(rst), .start(start15), .din(din15), .din_valid(vld15), .golden(golden15),
    .busy(busy15), .done(done15), .pass(pass15), .signature(sig15), .count(cnt15)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       start;
    logic [3:0] din;
    logic       vld;
    logic [3:0] golden;
    logic [3:0] sig;
    logic [1:0] cnt;
    logic       busy;
    logic       done;
    logic       pass;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic s, input logic [3:0] d, input logic v, input logic [3:0] g,
                      input logic [3:0] es, input logic [1:0] ec,
                      input logic eb, input logic ed, input logic ep);
    vec_t r;
    r.start = s; r.din = d; r.vld = v; r.golden = g;
    r.sig = es; r.cnt = ec; r.busy = eb; r.done = ed; r.pass = ep;
    vq.push_back(r);
  endtask

  logic [3:0] pat[15];

  task automatic run15(input int flip_idx, input logic [3:0] flip_mask, input logic [3:0] gold,
                       input logic exp_pass);
    start15  = 1'b1;
    golden15 = gold;
    tick();
    start15 = 1'b0;
    check("t6_start_busy", busy15, 1);
    for (int i = 0; i < 15; i++) begin
      din15 = pat[i] ^ ((i == flip_idx) ? flip_mask : 4'h0);
      vld15 = 1'b1;
      tick();
      if (i == 13) begin
        check("t6_not_done_at_14", done15, 0);
        check("t6_count_14", cnt15, 14);
      end
    end
    vld15 = 1'b0;
    check("t6_done", done15, 1);
    check("t6_count_15", cnt15, 15);
    check("t6_pass", pass15, exp_pass);
    if (exp_pass) check("t6_sig", sig15, 4'h9);
    else          check("t6_sig_differs", (sig15 != 4'h9), 1);
  endtask

  initial begin
    logic [3:0] l;

    // reset state
    #2;
    check("rst_busy", busy3, 0);
    check("rst_done", done3, 0);
    check("rst_pass", pass3, 0);
    check("rst_sig", sig3, 0);
    check("rst_cnt", cnt3, 0);
    @(negedge clk);
    rst = 1'b0;

    // T1: async reset mid-run
    start3 = 1'b1; golden3 = 4'h4; tick();
    start3 = 1'b0; din3 = 4'h1; vld3 = 1'b1; tick();
    din3 = 4'h0; tick();
    check("t1_cnt_before", cnt3, 2);
    #2 rst = 1'b1;
    #1;
    check("t1_busy", busy3, 0);
    check("t1_cnt", cnt3, 0);
    check("t1_sig", sig3, 0);
    check("t1_done", done3, 0);
    vld3 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    start3 = 1'b1; tick();
    start3 = 1'b0;
    check("t1_restart_busy", busy3, 1);
    check("t1_restart_cnt", cnt3, 0);
    din3 = 4'h1; vld3 = 1'b1; tick();
    check("t1_restart_cnt1", cnt3, 1);
    check("t1_restart_sig1", sig3, 1);
    vld3 = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    //   start din vld golden | sig cnt busy done pass
    // T2
    addv(1, 4'h5, 1, 4'h4,   4'h0, 0, 1, 0, 0);
    addv(0, 4'h1, 1, 4'h0,   4'h1, 1, 1, 0, 0);
    addv(0, 4'h0, 1, 4'h0,   4'h2, 2, 1, 0, 0);
    addv(0, 4'h0, 1, 4'h0,   4'h4, 3, 0, 1, 1);
    addv(0, 4'h7, 1, 4'h0,   4'h4, 3, 0, 1, 1);
    // T3
    addv(1, 4'h0, 0, 4'h6,   4'h0, 0, 1, 0, 0);
    addv(0, 4'h8, 1, 4'h0,   4'h8, 1, 1, 0, 0);
    addv(0, 4'h0, 1, 4'h0,   4'h3, 2, 1, 0, 0);
    addv(0, 4'h0, 1, 4'h0,   4'h6, 3, 0, 1, 1);
    addv(1, 4'h0, 0, 4'h5,   4'h0, 0, 1, 0, 0);
    addv(0, 4'h8, 1, 4'h0,   4'h8, 1, 1, 0, 0);
    addv(0, 4'h0, 1, 4'h0,   4'h3, 2, 1, 0, 0);
    addv(0, 4'h0, 1, 4'h0,   4'h6, 3, 0, 1, 0);
    // T4
    addv(1, 4'h0, 0, 4'h4,   4'h0, 0, 1, 0, 0);
    addv(0, 4'h1, 1, 4'h0,   4'h1, 1, 1, 0, 0);
    addv(0, 4'hF, 0, 4'h0,   4'h1, 1, 1, 0, 0);
    addv(0, 4'hA, 0, 4'h0,   4'h1, 1, 1, 0, 0);
    addv(0, 4'h0, 1, 4'h0,   4'h2, 2, 1, 0, 0);
    addv(0, 4'h5, 0, 4'h0,   4'h2, 2, 1, 0, 0);
    addv(0, 4'hC, 0, 4'h0,   4'h2, 2, 1, 0, 0);
    addv(0, 4'h0, 1, 4'h0,   4'h4, 3, 0, 1, 1);
    // T5
    addv(1, 4'h0, 0, 4'h6,   4'h0, 0, 1, 0, 0);
    addv(0, 4'h8, 1, 4'h0,   4'h8, 1, 1, 0, 0);
    addv(1, 4'h0, 1, 4'h4,   4'h3, 2, 1, 0, 0);
    addv(0, 4'h0, 1, 4'h0,   4'h6, 3, 0, 1, 1);
    addv(1, 4'h0, 0, 4'h6,   4'h0, 0, 1, 0, 0);
    addv(0, 4'h8, 1, 4'h0,   4'h8, 1, 1, 0, 0);
    addv(0, 4'h0, 1, 4'h0,   4'h3, 2, 1, 0, 0);
    addv(0, 4'h0, 1, 4'h0,   4'h6, 3, 0, 1, 1);

    foreach (vq[i]) begin
      start3 = vq[i].start; din3 = vq[i].din; vld3 = vq[i].vld; golden3 = vq[i].golden;
      tick();
      check($sformatf("vec%0d_sig", i),  sig3,  vq[i].sig);
      check($sformatf("vec%0d_cnt", i),  cnt3,  vq[i].cnt);
      check($sformatf("vec%0d_busy", i), busy3, vq[i].busy);
      check($sformatf("vec%0d_done", i), done3, vq[i].done);
      check($sformatf("vec%0d_pass", i), pass3, vq[i].pass);
    end
    start3 = 1'b0; vld3 = 1'b0;

    // T6: LFSR stream (seed 1, x^4+x+1) into the default instance
    l = 4'h1;
    for (int i = 0; i < 15; i++) begin
      pat[i] = l;
      l = {l[2:0], 1'b0} ^ (l[3] ? 4'b0011 : 4'b0000);
    end
    run15(-1, 4'h0, 4'h9, 1'b1);
    run15(0,  4'h1, 4'h9, 1'b0);
    run15(7,  4'h4, 4'h9, 1'b0);
    run15(14, 4'h8, 4'h9, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
